// File: rtl/clip_address_sequencer_if.sv
// Timer/address bundle between the recorder controller (master) and the clip sequencer (slave).
// halfMarker exists only when CLIP_HALF_MARKER_EN is defined.
interface clip_address_sequencer_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              enableTimer;
    logic              recordMode;
    logic [ADDR_W-1:0] startAddress;
    logic [ADDR_W-1:0] memAddress;
    logic              memWriteEn;
    logic              memReadEn;
    logic              sampleTick;
    logic              secondMarker;
    logic              busy;
`ifdef CLIP_HALF_MARKER_EN
    logic              halfMarker;
`endif

    modport master (
        output enableTimer, recordMode, startAddress,
`ifdef CLIP_HALF_MARKER_EN
        input  halfMarker,
`endif
        input  memAddress, memWriteEn, memReadEn, sampleTick, secondMarker, busy
    );

    modport slave (
        input  enableTimer, recordMode, startAddress,
`ifdef CLIP_HALF_MARKER_EN
        output halfMarker,
`endif
        output memAddress, memWriteEn, memReadEn, sampleTick, secondMarker, busy
    );
endinterface

// File: rtl/clip_address_sequencer.sv
// Paces sample-rate memory strobes through one clip and pulses secondMarker at clip end.
// Optional halfMarker output at the mid-clip tick is enabled by defining CLIP_HALF_MARKER_EN.
module clip_address_sequencer #(
    parameter int unsigned CLK_DIV      = 3125,
    parameter int unsigned CLIP_SAMPLES = 16000,
    parameter int unsigned ADDR_W       = 17
) (
    input logic                     clock,
    input logic                     reset,
    clip_address_sequencer_if.slave bus
);
    localparam int unsigned PreW    = $clog2(CLK_DIV);
    localparam int unsigned SampleW = $clog2(CLIP_SAMPLES);
    localparam logic [PreW-1:0]    PreMax  = PreW'(CLK_DIV - 1);
    localparam logic [SampleW-1:0] LastIdx = SampleW'(CLIP_SAMPLES - 1);
`ifdef CLIP_HALF_MARKER_EN
    localparam logic [SampleW-1:0] HalfIdx = SampleW'(CLIP_SAMPLES / 2);
`endif

    typedef enum logic [1:0] {Idle, Run, Done} state_t;

    state_t              state;
    logic                enablePrev;
    logic                modeQ;
    logic                lastTick;
    logic [PreW-1:0]     prescaler;
    logic [SampleW-1:0]  sampleCount;
    logic [ADDR_W-1:0]   nextAddress;
    logic [ADDR_W-1:0]   memAddressQ;
    logic                writeQ;
    logic                readQ;
    logic                tickQ;
    logic                secondQ;
    logic                busyQ;
`ifdef CLIP_HALF_MARKER_EN
    logic                halfQ;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= Idle;
            // Starts high so a level already present at reset release is not an edge.
            enablePrev  <= 1'b1;
            modeQ       <= 1'b0;
            lastTick    <= 1'b0;
            prescaler   <= '0;
            sampleCount <= '0;
            nextAddress <= '0;
            memAddressQ <= '0;
            writeQ      <= 1'b0;
            readQ       <= 1'b0;
            tickQ       <= 1'b0;
            secondQ     <= 1'b0;
            busyQ       <= 1'b0;
`ifdef CLIP_HALF_MARKER_EN
            halfQ       <= 1'b0;
`endif
        end else begin
            enablePrev <= bus.enableTimer;
            writeQ     <= 1'b0;
            readQ      <= 1'b0;
            tickQ      <= 1'b0;
            secondQ    <= 1'b0;
`ifdef CLIP_HALF_MARKER_EN
            halfQ      <= 1'b0;
`endif
            unique case (state)
                Idle: begin
                    if (bus.enableTimer && !enablePrev) begin
                        state       <= Run;
                        busyQ       <= 1'b1;
                        modeQ       <= bus.recordMode;
                        nextAddress <= bus.startAddress;
                        prescaler   <= '0;
                        sampleCount <= '0;
                        lastTick    <= 1'b0;
                    end
                end
                Run: begin
                    // Abort wins over both clip end and a tick due this cycle.
                    if (!bus.enableTimer) begin
                        state <= Idle;
                        busyQ <= 1'b0;
                    end else if (lastTick) begin
                        state   <= Done;
                        secondQ <= 1'b1;
                    end else if (prescaler == PreMax) begin
                        prescaler   <= '0;
                        tickQ       <= 1'b1;
                        writeQ      <= modeQ;
                        readQ       <= !modeQ;
                        memAddressQ <= nextAddress;
                        nextAddress <= nextAddress + 1'b1;
`ifdef CLIP_HALF_MARKER_EN
                        halfQ       <= (sampleCount == HalfIdx);
`endif
                        // Saturate on the final sample so the counter never wraps.
                        if (sampleCount == LastIdx) begin
                            lastTick <= 1'b1;
                        end else begin
                            sampleCount <= sampleCount + 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                Done: begin
                    state <= Idle;
                    busyQ <= 1'b0;
                end
                default: begin
                    state <= Idle;
                    busyQ <= 1'b0;
                end
            endcase
        end
    end

    assign bus.memAddress   = memAddressQ;
    assign bus.memWriteEn   = writeQ;
    assign bus.memReadEn    = readQ;
    assign bus.sampleTick   = tickQ;
    assign bus.secondMarker = secondQ;
    assign bus.busy         = busyQ;
`ifdef CLIP_HALF_MARKER_EN
    assign bus.halfMarker   = halfQ;
`endif

endmodule

// File: tb/tb_clip_address_sequencer.sv
// Directed bench for clip_address_sequencer with CLK_DIV=4, CLIP_SAMPLES=5.
// Cycle k means the outputs registered at the k-th rising edge after the start edge (k=0).
module tb_clip_address_sequencer;
    localparam int unsigned Div     = 4;
    localparam int unsigned Samples = 5;
    localparam int unsigned AddrW   = 17;

    logic clock;
    logic reset;
    int   numChecks;
    int   numErrors;

    clip_address_sequencer_if #(.ADDR_W(AddrW)) bus ();

    clip_address_sequencer #(
        .CLK_DIV      (Div),
        .CLIP_SAMPLES (Samples),
        .ADDR_W       (AddrW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkValue({tag, " tick"},   32'(bus.sampleTick),   32'd0);
        checkValue({tag, " write"},  32'(bus.memWriteEn),   32'd0);
        checkValue({tag, " read"},   32'(bus.memReadEn),    32'd0);
        checkValue({tag, " second"}, 32'(bus.secondMarker), 32'd0);
        checkValue({tag, " busy"},   32'(bus.busy),         32'd0);
    endtask

    // Starts a clip at the next edge (called at a falling edge) and checks every cycle.
    // abortAt < 0: no abort; otherwise enableTimer is sampled low at cycle abortAt.
    task automatic runClip(input logic [AddrW-1:0] start, input logic mode, input int abortAt,
                           input int cycles, input bit holdHigh);
        int  strobes;
        int  seconds;
        bit  expTick;
        bit  expSecond;
        bit  expBusy;
        int  idx;
        logic [AddrW-1:0] expAddr;
        strobes = 0;
        seconds = 0;
        bus.startAddress = start;
        bus.recordMode   = mode;
        bus.enableTimer  = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            idx     = int'(k / Div) - 1;
            expTick = (k > 0) && (k % Div == 0) && (k <= Div * Samples)
                      && (abortAt < 0 || k < abortAt);
            expSecond = (abortAt < 0) && (k == Div * Samples + 1);
            expBusy   = (abortAt < 0) ? (k <= Div * Samples + 1) : (k < abortAt);
            checkValue($sformatf("tick@%0d", k), 32'(bus.sampleTick), 32'(expTick));
            checkValue($sformatf("write@%0d", k), 32'(bus.memWriteEn), 32'(expTick && mode));
            checkValue($sformatf("read@%0d", k), 32'(bus.memReadEn), 32'(expTick && !mode));
            checkValue($sformatf("second@%0d", k), 32'(bus.secondMarker), 32'(expSecond));
            checkValue($sformatf("busy@%0d", k), 32'(bus.busy), 32'(expBusy));
`ifdef CLIP_HALF_MARKER_EN
            checkValue($sformatf("half@%0d", k), 32'(bus.halfMarker),
                       32'(expTick && idx == int'(Samples / 2)));
`endif
            if (expTick) begin
                expAddr = start + AddrW'(idx);
                checkValue($sformatf("addr@%0d", k), 32'(bus.memAddress), 32'(expAddr));
            end
            if (bus.memWriteEn || bus.memReadEn) strobes++;
            if (bus.secondMarker) seconds++;
            // Mid-clip input changes must not disturb the running clip.
            if (k == 6) begin
                bus.startAddress = ~start;
                bus.recordMode   = ~mode;
            end
            if (abortAt >= 0 && k == abortAt - 1) bus.enableTimer = 1'b0;
        end
        if (abortAt < 0) begin
            checkValue("strobe count", 32'(strobes), 32'(Samples));
            checkValue("second count", 32'(seconds), 32'd1);
        end else begin
            checkValue("abort strobe count", 32'(strobes), 32'((abortAt - 1) / Div));
            checkValue("abort second count", 32'(seconds), 32'd0);
        end
        if (!holdHigh) begin
            bus.enableTimer = 1'b0;
            @(negedge clock);
        end
    endtask

    initial begin
        numChecks        = 0;
        numErrors        = 0;
        reset            = 1'b1;
        bus.enableTimer  = 1'b0;
        bus.recordMode   = 1'b0;
        bus.startAddress = '0;
        repeat (3) @(negedge clock);
        checkIdleOutputs("reset");
        checkValue("reset addr", 32'(bus.memAddress), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Record clip.
        runClip(17'h00010, 1'b1, -1, 24, 1'b0);
        // Play clip wrapping through the top of the address space.
        runClip(17'h1FFFE, 1'b0, -1, 24, 1'b0);
        // Abort after two ticks.
        runClip(17'h00040, 1'b1, 10, 24, 1'b0);

        // Asynchronous reset in the middle of a clip.
        bus.startAddress = 17'h00100;
        bus.recordMode   = 1'b1;
        bus.enableTimer  = 1'b1;
        repeat (7) @(negedge clock);
        checkValue("pre-reset busy", 32'(bus.busy), 32'd1);
        checkValue("pre-reset addr", 32'(bus.memAddress), 32'h100);
        #2 reset = 1'b1;
        #1;
        checkIdleOutputs("async reset");
        checkValue("async reset addr", 32'(bus.memAddress), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            checkValue($sformatf("held-high busy@%0d", k), 32'(bus.busy), 32'd0);
            checkValue($sformatf("held-high tick@%0d", k), 32'(bus.sampleTick), 32'd0);
        end
        bus.enableTimer = 1'b0;
        @(negedge clock);
        runClip(17'h00200, 1'b0, -1, 24, 1'b0);

        // Enable held high long after completion: exactly one clip, then a toggle restarts.
        runClip(17'h00300, 1'b1, -1, 22 + 40, 1'b1);
        bus.enableTimer = 1'b0;
        @(negedge clock);
        runClip(17'h00400, 1'b1, -1, 24, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/clip_address_sequencer.md
Name: clip_address_sequencer

Overview:
Responder side of the recorder controller's timer/address interface. It accepts the controller's timer enable, start address and mode, then paces sample-rate memory strobes through one clip. When the clip's full sample count has elapsed, it returns the one-cycle secondMarker pulse the controller uses to return to standby. It sits between the controller and the clip SRAM / serializer / deserializer.

Parameters:
CLK_DIV, 3125, system clocks per sample period (50 MHz / 16 kHz); minimum 2
CLIP_SAMPLES, 16000, samples per clip (one second); minimum 2
ADDR_W, 17, memory address width; matches the controller's startAddress

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
enableTimer  input  1  level from the controller; its rising edge starts a clip, a low level aborts it
recordMode  input  1  1 = record (write strobes), 0 = play (read strobes); captured at start
startAddress  input  ADDR_W  first sample address; captured at start
memAddress  output  ADDR_W  address for the current strobe
memWriteEn  output  1  one-cycle write strobe (record)
memReadEn  output  1  one-cycle read strobe (play)
sampleTick  output  1  one-cycle pulse per sample period; serializer/deserializer advance on it
secondMarker  output  1  one-cycle pulse at clip completion
busy  output  1  high while state is RUN or DONE

Behaviour:
- Clock and reset: one clock, `clock`. Reset is `reset`, asynchronous and active-high. While reset is asserted:
  - all outputs are 0, memAddress is 0 and state is IDLE;
  - the enableTimer edge register resets to 1, so an enableTimer already high at reset release does not start a clip. A fresh low-to-high transition is required.
- All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE:
  - All strobes are 0.
  - A rising edge is enableTimer==1 with the previous sample 0.
  - On a rising edge (edge cycle = cycle 0): capture startAddress into the address counter, capture recordMode, clear the prescaler and the sample counter, and go to RUN.
- RUN, prescaler:
  - The prescaler counts 0..CLK_DIV-1 and wraps.
  - Whenever it wraps, the next cycle asserts sampleTick together with memWriteEn (captured mode 1) or memReadEn (captured mode 0) for one cycle.
  - memAddress holds the address for that strobe, and remains stable until the next strobe.
- RUN, tick timing: the first tick is at cycle CLK_DIV. Subsequent ticks are exactly CLK_DIV cycles apart.
- RUN, address and sample counting:
  - After each strobe the address increments modulo 2^ADDR_W: 0x1FFFF is followed by 0x00000, with no flag.
  - The sample counter increments on each tick.
- RUN, clip end:
  - The tick carrying sample index CLIP_SAMPLES-1 (0-based) is the last one.
  - The following cycle moves to DONE.
- DONE: secondMarker=1 for exactly one cycle, then go to IDLE. busy falls in the cycle after DONE.
- Abort: if enableTimer is 0 in any RUN cycle, go to IDLE next cycle. In that case:
  - no further ticks or strobes;
  - no secondMarker;
  - busy falls that cycle.
- Abort priority: abort takes priority over a tick due in the same cycle.
- No retrigger: enableTimer held high after DONE does not restart. A new clip requires enableTimer low for at least 1 cycle, then high.
- Input changes during RUN: startAddress and recordMode changes are ignored.
- Exclusivity: memWriteEn and memReadEn are never high together.
- Counter widths: prescaler is $clog2(CLK_DIV) bits; sample counter is $clog2(CLIP_SAMPLES) bits. Neither counter overflows.

Optional Feature:
- Macro: CLIP_HALF_MARKER_EN
- When defined:
  - adds output port halfMarker (1 bit, reset 0);
  - halfMarker pulses together with the tick whose 0-based sample index == CLIP_SAMPLES/2 (integer floor);
  - it is not asserted on aborted clips after the abort.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
All scenarios use CLK_DIV=4 and CLIP_SAMPLES=5.
1. Record: reset, then startAddress=0x00010, recordMode=1, enableTimer 0->1 at cycle 0 -> memWriteEn pulses at cycles 4, 8, 12, 16, 20 with memAddress 0x10..0x14; memReadEn stays 0; secondMarker at cycle 21 only; busy 0 from cycle 22.
2. Play with wrap: startAddress=0x1FFFE, recordMode=0 -> memReadEn with addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001, 0x00002, then a single secondMarker.
3. Abort: drop enableTimer at cycle 10 (after 2 ticks) -> no tick at cycle 12 or later; secondMarker never asserted; busy low by cycle 11.
4. Async reset mid-RUN at cycle 6, with no clock edge yet -> all outputs 0 immediately. After release with enableTimer still high -> no activity; enableTimer low 1 cycle then high -> new clip starts from the current startAddress.
5. Retrigger guard: enableTimer held high through DONE for 40 cycles -> exactly one clip (5 strobes, one secondMarker). Low-high toggle -> a second full clip.
6. With CLIP_HALF_MARKER_EN defined: scenario 1 -> halfMarker high only at cycle 12 (index 2). Without the macro -> the port is absent and the bench compiles and passes scenarios 1-5 unchanged.
